// File: rtl/reg_freelist_pkg.sv
// Shared constants and helpers for the rename / commit / free-list slice.
//   NUM_WAYS   : rename and commit width (slots per cycle)
//   N_ARCH     : architectural registers, mapped to p0..p(N_ARCH-1) at reset
//   PREG_W     : physical register address width
//   popcount4  : number of set bits in a 4-bit slot vector (0..4)
package reg_freelist_pkg;

    localparam int NUM_WAYS = 4;
    localparam int N_ARCH   = 32;
    localparam int PREG_W   = 7;

    typedef logic [NUM_WAYS-1:0] way_vec_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/reg_freelist_pack.sv
// freelist_pack: turns a 4-bit slot valid vector into per-slot packing
// offsets (the number of valid slots below each slot) and the total count.
//   i_valid  : per-slot valid, slot 0 = oldest
//   o_off0-3 : offset of each slot within the packed group (0..3)
//   o_total  : popcount of i_valid (0..4)
module freelist_pack
    import reg_freelist_pkg::*;
(
    input  logic [3:0] i_valid,
    output logic [1:0] o_off0,
    output logic [1:0] o_off1,
    output logic [1:0] o_off2,
    output logic [1:0] o_off3,
    output logic [2:0] o_total
);

    // Prefix counts never exceed 3, so the narrowing is lossless.
    always_comb begin
        o_off0  = '0;
        o_off1  = 2'(popcount4({3'b000, i_valid[0]}));
        o_off2  = 2'(popcount4({2'b00, i_valid[1:0]}));
        o_off3  = 2'(popcount4({1'b0, i_valid[2:0]}));
        o_total = popcount4(i_valid);
    end

endmodule

// File: rtl/reg_freelist.sv
// reg_freelist: physical-register free list for the 4-wide rename stage.
// Circular buffer of DEPTH = 2**WIDTH - N_ARCH entries with explicit
// (non-power-of-two) pointer wrap.
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_alloc_req           : per-slot allocation request (slot 0 oldest)
//   o_alloc_ok            : enough free entries for all requests (comb)
//   o_alloc_addr0..3      : allocated register per requesting slot (comb)
//   i_free_en             : per-slot release valid from commit
//   i_free_addr0..3       : released registers
//   o_count, o_empty      : free entry count and empty flag
//   o_err                 : sticky overflow flag, cleared by reset only
module reg_freelist #(
    parameter int WIDTH  = reg_freelist_pkg::PREG_W,
    parameter int N_ARCH = reg_freelist_pkg::N_ARCH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_alloc_req,
    output logic             o_alloc_ok,
    output logic [WIDTH-1:0] o_alloc_addr0,
    output logic [WIDTH-1:0] o_alloc_addr1,
    output logic [WIDTH-1:0] o_alloc_addr2,
    output logic [WIDTH-1:0] o_alloc_addr3,
    input  logic [3:0]       i_free_en,
    input  logic [WIDTH-1:0] i_free_addr0,
    input  logic [WIDTH-1:0] i_free_addr1,
    input  logic [WIDTH-1:0] i_free_addr2,
    input  logic [WIDTH-1:0] i_free_addr3,
    output logic [WIDTH-1:0] o_count,
    output logic             o_empty,
    output logic             o_err
);

    import reg_freelist_pkg::*;

    localparam int             DEPTH   = (2 ** WIDTH) - N_ARCH;
    localparam logic [WIDTH:0] DEPTH_X = (WIDTH + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    // ptr + n with explicit wrap at DEPTH (n <= 4, so one subtraction suffices).
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] ptr,
                                                  input logic [2:0]       n);
        logic [WIDTH:0] s;
        s = {1'b0, ptr} + (WIDTH + 1)'(n);
        if (s >= DEPTH_X) s = s - DEPTH_X;
        return s[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] mem_d   [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [1:0]       a_off [4];
    logic [2:0]       a_total;
    logic [1:0]       f_off [4];
    logic [2:0]       f_total;

    logic [WIDTH-1:0] free_addr [4];
    way_vec_t         free_valid;
    way_vec_t         free_acc;
    logic             alloc_ok;
    logic [WIDTH-1:0] after_alloc;
    logic [WIDTH-1:0] alloc_addr [4];

    assign free_addr[0] = i_free_addr0;
    assign free_addr[1] = i_free_addr1;
    assign free_addr[2] = i_free_addr2;
    assign free_addr[3] = i_free_addr3;

    freelist_pack u_alloc_pack (
        .i_valid (i_alloc_req),
        .o_off0  (a_off[0]),
        .o_off1  (a_off[1]),
        .o_off2  (a_off[2]),
        .o_off3  (a_off[3]),
        .o_total (a_total)
    );

    freelist_pack u_free_pack (
        .i_valid (free_acc),
        .o_off0  (f_off[0]),
        .o_off1  (f_off[1]),
        .o_off2  (f_off[2]),
        .o_off3  (f_off[3]),
        .o_total (f_total)
    );

    // Allocation peek: requesting slots read consecutive entries from head.
    always_comb begin
        alloc_ok = (count_q >= WIDTH'(a_total));
        for (int unsigned k = 0; k < 4; k++) begin
            if (i_alloc_req[k]) alloc_addr[k] = mem_q[wrap_add(head_q, {1'b0, a_off[k]})];
            else                alloc_addr[k] = mem_q[head_q];
        end
    end

    // Release acceptance: p0 is never returned to the list; when releases
    // would exceed capacity, the lowest valid slots win and the rest drop.
    always_comb begin
        logic [WIDTH-1:0] room;
        logic [2:0]       taken;
        after_alloc = count_q - (alloc_ok ? WIDTH'(a_total) : '0);
        room        = DEPTH_W - after_alloc;
        taken       = '0;
        free_valid  = '0;
        free_acc    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            free_valid[k] = i_free_en[k] && (free_addr[k] != '0);
            if (free_valid[k] && (WIDTH'(taken) < room)) begin
                free_acc[k] = 1'b1;
                taken       = taken + 3'd1;
            end
        end
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = alloc_ok ? wrap_add(head_q, a_total) : head_q;
        tail_d  = wrap_add(tail_q, f_total);
        count_d = after_alloc + WIDTH'(f_total);
        err_d   = err_q | (|(free_valid & ~free_acc));
        for (int unsigned k = 0; k < 4; k++) begin
            if (free_acc[k]) mem_d[wrap_add(tail_q, {1'b0, f_off[k]})] = free_addr[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(N_ARCH + int'(i));
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_W;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_alloc_ok    = alloc_ok;
    assign o_alloc_addr0 = alloc_addr[0];
    assign o_alloc_addr1 = alloc_addr[1];
    assign o_alloc_addr2 = alloc_addr[2];
    assign o_alloc_addr3 = alloc_addr[3];
    assign o_count       = count_q;
    assign o_empty       = (count_q == '0);
    assign o_err         = err_q;

endmodule

// File: tb/tb_reg_freelist.sv
// Scoreboard bench for reg_freelist: a FIFO-queue reference model predicts
// each cycle's outputs; a negedge monitor pops and compares.
module tb_reg_freelist;

    localparam int W     = 7;
    localparam int NA    = 32;
    localparam int DEPTH = 96;

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [3:0]   i_alloc_req = '0;
    logic         o_alloc_ok;
    logic [W-1:0] o_alloc_addr0, o_alloc_addr1, o_alloc_addr2, o_alloc_addr3;
    logic [3:0]   i_free_en = '0;
    logic [W-1:0] i_free_addr0 = '0, i_free_addr1 = '0, i_free_addr2 = '0, i_free_addr3 = '0;
    logic [W-1:0] o_count;
    logic         o_empty;
    logic         o_err;
    logic [W-1:0] dut_addr [4];

    always #5 clk = ~clk;

    reg_freelist #(.WIDTH(W), .N_ARCH(NA)) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_alloc_req   (i_alloc_req),
        .o_alloc_ok    (o_alloc_ok),
        .o_alloc_addr0 (o_alloc_addr0),
        .o_alloc_addr1 (o_alloc_addr1),
        .o_alloc_addr2 (o_alloc_addr2),
        .o_alloc_addr3 (o_alloc_addr3),
        .i_free_en     (i_free_en),
        .i_free_addr0  (i_free_addr0),
        .i_free_addr1  (i_free_addr1),
        .i_free_addr2  (i_free_addr2),
        .i_free_addr3  (i_free_addr3),
        .o_count       (o_count),
        .o_empty       (o_empty),
        .o_err         (o_err)
    );

    assign dut_addr[0] = o_alloc_addr0;
    assign dut_addr[1] = o_alloc_addr1;
    assign dut_addr[2] = o_alloc_addr2;
    assign dut_addr[3] = o_alloc_addr3;

    typedef struct {
        bit       chk;
        bit [3:0] req;
        bit       ok;
        int       addr [4];
        int       count;
        bit       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the free list is simply a FIFO of register numbers.
    int   fl[$];
    bit   m_err   = 1'b0;
    bit   m_valid = 1'b0;
    int   held[$];   // registers currently allocated, candidates for release

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        fl.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(NA + i);
        m_err   = 1'b0;
        m_valid = 1'b1;
        held.delete();
    endtask

    task automatic drive(input bit rst_n, input bit [3:0] req, input bit [3:0] fen,
                         input int a0, input int a1, input int a2, input int a3);
        exp_t e;
        int   fa [4];
        int   j;
        fa = '{a0, a1, a2, a3};
        i_rst_n      = rst_n;
        i_alloc_req  = req;
        i_free_en    = fen;
        i_free_addr0 = W'(a0);
        i_free_addr1 = W'(a1);
        i_free_addr2 = W'(a2);
        i_free_addr3 = W'(a3);

        e.chk   = m_valid;
        e.req   = req;
        e.ok    = ($countones(req) <= fl.size());
        e.count = fl.size();
        e.err   = m_err;
        j = 0;
        for (int k = 0; k < 4; k++) begin
            e.addr[k] = 0;
            if (req[k] && e.ok) begin
                e.addr[k] = fl[j];
                j++;
            end
        end
        exp_q.push_back(e);

        if (!rst_n) begin
            reset_model();
        end else begin
            if (e.ok) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[k]) held.push_back(fl.pop_front());
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (fen[k] && fa[k] != 0) begin
                    if (fl.size() < DEPTH) fl.push_back(fa[k]);
                    else m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    endtask

    // Monitor: combinational outputs are stable by the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("alloc_ok", int'(o_alloc_ok), int'(e.ok));
                    if (e.ok) begin
                        for (int k = 0; k < 4; k++) begin
                            if (e.req[k]) check($sformatf("alloc_addr%0d", k), int'(dut_addr[k]), e.addr[k]);
                        end
                    end
                    check("count", int'(o_count), e.count);
                    check("empty", int'(o_empty), int'(e.count == 0));
                    check("err", int'(o_err), int'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fa [4];
        bit [3:0] fen;
        bit rst_n;
        int r;
        int idx;

        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // Full-width allocation from reset: 32..35, then count 92.
        drive(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0);
        idle();

        // Sparse request packs into consecutive entries; then overflow.
        do_reset();
        drive(1'b1, 4'b1010, 4'b0000, 0, 0, 0, 0);
        drive(1'b1, 4'b0000, 4'b1111, 32, 33, 50, 51);
        idle();
        drive(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0);
        // Reset wins over a same-cycle allocation and clears the error.
        drive(1'b0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        idle();

        // Drain to 2, reject an oversized request, empty, then turnaround.
        for (int i = 0; i < 23; i++) drive(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0);
        drive(1'b1, 4'b0011, 4'b0000, 0, 0, 0, 0);
        drive(1'b1, 4'b0111, 4'b0000, 0, 0, 0, 0);
        drive(1'b1, 4'b0011, 4'b0000, 0, 0, 0, 0);
        drive(1'b1, 4'b0011, 4'b0111, 40, 41, 0, 0);
        drive(1'b1, 4'b0011, 4'b0000, 0, 0, 0, 0);
        idle();

        // Pointer wrap: steady alloc-4 / free-4 recycling.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            fen = 4'b0000;
            fa  = '{0, 0, 0, 0};
            if (held.size() >= 4) begin
                fen = 4'b1111;
                for (int k = 0; k < 4; k++) fa[k] = held.pop_front();
            end
            drive(1'b1, 4'b1111, fen, fa[0], fa[1], fa[2], fa[3]);
        end
        idle();

        // Randomized traffic with occasional garbage releases and resets.
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            fen   = 4'b0000;
            fa    = '{0, 0, 0, 0};
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 9);
                if (r < 5 && held.size() > 0) begin
                    idx    = $urandom_range(0, held.size() - 1);
                    fa[k]  = held[idx];
                    held.delete(idx);
                    fen[k] = 1'b1;
                end else if (r == 5) begin
                    fa[k]  = $urandom_range(0, 127);
                    fen[k] = 1'b1;
                end
            end
            drive(rst_n, 4'($urandom), fen, fa[0], fa[1], fa[2], fa[3]);
        end
        idle();

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_freelist.md
Name: reg_freelist

Overview:
- Physical-register free list for the 4-wide rename stage.
- Hands up to 4 free physical register numbers per cycle to rename; these become the write addresses of the 8-read/4-write physical register file.
- Takes back up to 4 released physical registers per cycle from commit.
- Circular buffer with non-power-of-two depth; allocation is all-or-nothing per cycle.

Parameters:
WIDTH, 7, physical register address width (2**WIDTH physical registers)
N_ARCH, 32, architectural registers; p0..p(N_ARCH-1) are mapped at reset and never in the list initially
DEPTH, 2**WIDTH-N_ARCH (96), free-list capacity; derived, not overridable

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset, sampled on rising edge of i_clk
i_alloc_req  in  4  per-slot allocation request, slot 0 = oldest instruction
o_alloc_ok  out  1  enough free entries exist for popcount(i_alloc_req); combinational
o_alloc_addr0..3  out  WIDTH each  physical register for each requesting slot; valid when matching req bit and o_alloc_ok
i_free_en  in  4  per-slot release valid from commit
i_free_addr0..3  in  WIDTH each  physical register being released
o_count  out  WIDTH  number of free entries (0..DEPTH)
o_empty  out  1  o_count == 0
o_err  out  1  sticky overflow / illegal-release flag

Behaviour:
- Storage: mem[0..DEPTH-1] of WIDTH bits, head and tail pointers in 0..DEPTH-1, count register.
- Reset (i_rst_n low at clock edge): mem[i] = N_ARCH+i, head=0, tail=0, count=DEPTH, o_err=0. Resulting outputs: o_count=96, o_empty=0, o_alloc_ok=1.
- Reset has priority over any alloc/free in the same cycle.
- Pointer wrap is explicit: if ptr+n >= DEPTH then ptr+n-DEPTH. No power-of-two masking.
- Allocation (combinational peek, commit on edge):
  - n_alloc = popcount(i_alloc_req).
  - o_alloc_ok = (count >= n_alloc). Always 1 when n_alloc=0.
  - Slot k uses offset = popcount(i_alloc_req[k-1:0]): o_alloc_addrk = mem[wrap(head+offset)]. Requesting slots are packed in slot order.
  - Non-requesting slot outputs are don't-care; drive the head entry.
  - On edge, if o_alloc_ok: head += n_alloc and count -= n_alloc.
  - If !o_alloc_ok, nothing is consumed; rename stalls and re-requests.
- Release:
  - Valid slots are packed in slot order: slot k writes mem[wrap(tail + popcount(valid_below_k))].
  - tail += n_free on edge.
  - A valid release with address < N_ARCH and == 0 (p0, hardwired zero) is dropped: not counted, not written.
- Simultaneous alloc and free: count_next = count - n_alloc + n_free.
  - Alloc sees only entries present at the start of the cycle. Freed registers are allocatable the next cycle (1-cycle turnaround, no bypass).
- Overflow: if count - n_alloc + n_free > DEPTH, the excess releases (highest slots) are dropped and o_err is set; o_err clears only on reset.
- Latency: addresses valid the same cycle as the request; o_count reflects the edge update the next cycle.
- Reset mid-operation discards all in-flight frees and allocations; the list returns to its reset contents.

Decomposition:
- Shared package holds: NUM_WAYS=4, N_ARCH=32, PREG_W=7, and a function popcount4 (also used by rename/commit).
- One sub-module, freelist_pack (4-bit valid vector -> per-slot prefix offsets 0..3 plus total 0..4). It is instantiated twice: once for alloc, once for free.

Test Plan:
- Reset then i_alloc_req=4'b1111 -> o_alloc_ok=1, addrs 32,33,34,35. Next cycle o_count=92.
- i_alloc_req=4'b1010 after reset -> o_alloc_addr1=32, o_alloc_addr3=33. Next o_count=94, next head entry 34.
- Drain to count=2, request 4'b0111 -> o_alloc_ok=0, count stays 2. Request 4'b0011 -> ok, count 0, o_empty=1.
- Same cycle: alloc 2 and free 3 (addrs 40,41,0) with count=0 -> o_alloc_ok=0 that cycle. Next count=2 (p0 dropped); next alloc returns 40,41.
- Wrap: 24 cycles of alloc-4 plus free-4 -> head and tail wrap 95->0. Returned addresses follow FIFO order across the wrap.
- Free 4 at count=94 -> count=96, o_err=1 (two dropped). Assert reset together with alloc=1111 -> count=96, o_err=0.
